data_cache_assoc: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate data cache between the RV32IM pipeline MEM stage and the block-wide data memory. It generalises the direct-mapped cache in set count, associativity and block size. It adds true-LRU replacement and byte-enabled stores for SB/SH. It stalls the CPU through BUSYWAIT only on misses; hits complete in the request cycle.

---
 rtl/data_cache_if.sv | 29 ++
 rtl/data_cache_assoc.sv | 152 +++++++++++++++
 tb/tb_data_cache_assoc.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_cache_if.sv
// CPU-side and memory-side signal bundle for data_cache_assoc.
// The cache binds to the slave modport; the pipeline/memory model binds to master.
interface data_cache_if #(parameter int WORDS = 4);
    localparam int BAW = 30 - $clog2(WORDS);

    logic              MEM_READ;
    logic              MEM_WRITE;
    logic [31:0]       MEM_ADDRESS;
    logic [31:0]       DATA_IN;
    logic [3:0]        BYTE_EN;
    logic [31:0]       CACHE_READ_OUT;
    logic              BUSYWAIT;
    logic              MEM_MEM_READ;
    logic              MEM_MEM_WRITE;
    logic [BAW-1:0]    MEM_BLOCK_ADDR;
    logic [32*WORDS-1:0] MEM_WRITE_OUT;
    logic              MEM_BUSYWAIT;
    logic [32*WORDS-1:0] MEM_READ_OUT;

    modport slave (
        input  MEM_READ, MEM_WRITE, MEM_ADDRESS, DATA_IN, BYTE_EN, MEM_BUSYWAIT, MEM_READ_OUT,
        output CACHE_READ_OUT, BUSYWAIT, MEM_MEM_READ, MEM_MEM_WRITE, MEM_BLOCK_ADDR, MEM_WRITE_OUT
    );

    modport master (
        output MEM_READ, MEM_WRITE, MEM_ADDRESS, DATA_IN, BYTE_EN, MEM_BUSYWAIT, MEM_READ_OUT,
        input  CACHE_READ_OUT, BUSYWAIT, MEM_MEM_READ, MEM_MEM_WRITE, MEM_BLOCK_ADDR, MEM_WRITE_OUT
    );
endinterface

// File: rtl/data_cache_assoc.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU ages.
// Hits complete combinationally in the request cycle; misses run WBACK/FETCH.
module data_cache_assoc #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 4
) (
    input logic        CLK,
    input logic        RESET,
    data_cache_if.slave bus
);
    localparam int IW  = $clog2(SETS);
    localparam int OW  = $clog2(WORDS);
    localparam int TW  = 30 - IW - OW;
    localparam int AGW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BW  = 32 * WORDS;

    typedef enum logic [1:0] {IDLE, WBACK, FETCH} state_t;

    state_t state_q, state_d;

    logic           valid_q [SETS][WAYS];
    logic           dirty_q [SETS][WAYS];
    logic [TW-1:0]  tag_q   [SETS][WAYS];
    logic [BW-1:0]  data_q  [SETS][WAYS];
    logic [AGW-1:0] age_q   [SETS][WAYS];

    logic [TW-1:0]   tag;
    logic [IW-1:0]   idx;
    logic [OW-1:0]   wsel;
    logic            unused_byte_bits;
    logic [WAYS-1:0] hit_vec;
    logic            hit, idle_hit, req, is_rd, is_wr, fill, wr_hit, touch;
    logic [AGW-1:0]  hit_way, victim, vic_inv, vic_old, touch_way;
    logic            all_valid;
    logic [BW-1:0]   hit_blk;

    assign tag  = bus.MEM_ADDRESS[31 -: TW];
    assign idx  = bus.MEM_ADDRESS[2+OW +: IW];
    assign wsel = bus.MEM_ADDRESS[2 +: OW];
    assign unused_byte_bits = ^bus.MEM_ADDRESS[1:0];

    for (genvar w = 0; w < WAYS; w++) begin : g_cmp
        assign hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
    end

    assign hit = |hit_vec;

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (hit_vec[w]) hit_way = AGW'(w);
    end

    // Prefer the lowest invalid way; only when the set is full does LRU age decide.
    always_comb begin
        vic_inv   = '0;
        vic_old   = '0;
        all_valid = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                vic_inv   = AGW'(w);
                all_valid = 1'b0;
            end
            if (age_q[idx][w] == AGW'(WAYS - 1)) vic_old = AGW'(w);
        end
        victim = all_valid ? vic_old : vic_inv;
    end

    assign req      = bus.MEM_READ | bus.MEM_WRITE;
    assign is_wr    = bus.MEM_WRITE;
    assign is_rd    = bus.MEM_READ & ~bus.MEM_WRITE;
    assign idle_hit = (state_q == IDLE) && hit;
    assign fill     = (state_q == FETCH) && !bus.MEM_BUSYWAIT;
    assign wr_hit   = idle_hit && is_wr;
    assign touch    = (idle_hit && req) || fill;
    assign touch_way = fill ? victim : hit_way;

    assign hit_blk            = data_q[idx][hit_way];
    assign bus.BUSYWAIT       = req && !idle_hit;
    assign bus.CACHE_READ_OUT = (idle_hit && is_rd) ? hit_blk[32*wsel +: 32] : 32'h0;

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d            = state_q;
        bus.MEM_MEM_READ   = 1'b0;
        bus.MEM_MEM_WRITE  = 1'b0;
        bus.MEM_BLOCK_ADDR = '0;
        bus.MEM_WRITE_OUT  = '0;
        case (state_q)
            IDLE: begin
                if (req && !hit)
                    state_d = (valid_q[idx][victim] && dirty_q[idx][victim]) ? WBACK : FETCH;
            end
            WBACK: begin
                bus.MEM_MEM_WRITE  = 1'b1;
                bus.MEM_BLOCK_ADDR = {tag_q[idx][victim], idx};
                bus.MEM_WRITE_OUT  = data_q[idx][victim];
                if (!bus.MEM_BUSYWAIT) state_d = FETCH;
            end
            FETCH: begin
                bus.MEM_MEM_READ   = 1'b1;
                bus.MEM_BLOCK_ADDR = bus.MEM_ADDRESS[31:2+OW];
                if (!bus.MEM_BUSYWAIT) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line status and ages; reset restores the age permutation 0..WAYS-1.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= AGW'(w);
                end
        end else begin
            if (fill) begin
                valid_q[idx][victim] <= 1'b1;
                dirty_q[idx][victim] <= 1'b0;
            end else if (wr_hit) begin
                dirty_q[idx][hit_way] <= 1'b1;
            end
            if (touch)
                for (int w = 0; w < WAYS; w++) begin
                    if (AGW'(w) == touch_way)
                        age_q[idx][w] <= '0;
                    else if (age_q[idx][w] < age_q[idx][touch_way])
                        age_q[idx][w] <= age_q[idx][w] + 1'b1;
                end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (fill) begin
                tag_q[idx][victim]  <= tag;
                data_q[idx][victim] <= bus.MEM_READ_OUT;
            end else if (wr_hit) begin
                for (int b = 0; b < 4; b++)
                    if (bus.BYTE_EN[b])
                        data_q[idx][hit_way][32*wsel + 8*b +: 8] <= bus.DATA_IN[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_cache_assoc.sv
// Random and directed checks of data_cache_assoc against an LRU-list reference model,
// covering the default geometry and a 16-set/4-way/8-word instance.
module tb_data_cache_assoc;
    logic clk, rst;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, data_in;
    logic [3:0]  byte_en;

    data_cache_if #(.WORDS(4)) ifa ();
    data_cache_if #(.WORDS(8)) ifb ();

    data_cache_assoc dut_a (.CLK(clk), .RESET(rst), .bus(ifa));
    data_cache_assoc #(.SETS(16), .WAYS(4), .WORDS(8)) dut_b (.CLK(clk), .RESET(rst), .bus(ifb));

    assign ifa.MEM_READ = mem_read;     assign ifb.MEM_READ = mem_read;
    assign ifa.MEM_WRITE = mem_write;   assign ifb.MEM_WRITE = mem_write;
    assign ifa.MEM_ADDRESS = mem_address; assign ifb.MEM_ADDRESS = mem_address;
    assign ifa.DATA_IN = data_in;       assign ifb.DATA_IN = data_in;
    assign ifa.BYTE_EN = byte_en;       assign ifb.BYTE_EN = byte_en;

    initial begin clk = 1'b0; forever #5 clk = ~clk; end

    int n_cmp = 0, n_err = 0;
    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- memory model (3 busy cycles per request) ----------------
    function automatic logic [31:0] initw(input int i);
        return (32'(i) * 32'h0101_0193) ^ 32'h5A00_0000;
    endfunction

    logic [31:0] pmem_a [1024];
    logic [31:0] pmem_b [1024];
    int  cnt_a, cnt_b;
    bit  mem_init;

    assign ifa.MEM_BUSYWAIT = (ifa.MEM_MEM_READ | ifa.MEM_MEM_WRITE) && (cnt_a < 3);
    assign ifb.MEM_BUSYWAIT = (ifb.MEM_MEM_READ | ifb.MEM_MEM_WRITE) && (cnt_b < 3);

    always_comb begin
        ifa.MEM_READ_OUT = '0;
        for (int i = 0; i < 4; i++)
            ifa.MEM_READ_OUT[32*i +: 32] = pmem_a[(int'(ifa.MEM_BLOCK_ADDR) * 4 + i) & 1023];
    end
    always_comb begin
        ifb.MEM_READ_OUT = '0;
        for (int i = 0; i < 8; i++)
            ifb.MEM_READ_OUT[32*i +: 32] = pmem_b[(int'(ifb.MEM_BLOCK_ADDR) * 8 + i) & 1023];
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) begin
                pmem_a[i] <= (i == 16) ? 32'hAAAA_AAAA : (i == 17) ? 32'hCCCC_CCCC :
                             (i == 18) ? 32'h1122_3344 : (i == 19) ? 32'hDDDD_DDDD : initw(i);
                pmem_b[i] <= (i == 16) ? 32'hAAAA_AAAA : (i == 17) ? 32'hCCCC_CCCC :
                             (i == 18) ? 32'h1122_3344 : (i == 19) ? 32'hDDDD_DDDD : initw(i);
            end
            cnt_a <= 0;
            cnt_b <= 0;
        end else begin
            if (ifa.MEM_MEM_READ | ifa.MEM_MEM_WRITE) begin
                if (!ifa.MEM_BUSYWAIT) begin
                    cnt_a <= 0;
                    if (ifa.MEM_MEM_WRITE)
                        for (int i = 0; i < 4; i++)
                            pmem_a[(int'(ifa.MEM_BLOCK_ADDR) * 4 + i) & 1023] <= ifa.MEM_WRITE_OUT[32*i +: 32];
                end else cnt_a <= cnt_a + 1;
            end else cnt_a <= 0;
            if (ifb.MEM_MEM_READ | ifb.MEM_MEM_WRITE) begin
                if (!ifb.MEM_BUSYWAIT) begin
                    cnt_b <= 0;
                    if (ifb.MEM_MEM_WRITE)
                        for (int i = 0; i < 8; i++)
                            pmem_b[(int'(ifb.MEM_BLOCK_ADDR) * 8 + i) & 1023] <= ifb.MEM_WRITE_OUT[32*i +: 32];
                end else cnt_b <= cnt_b + 1;
            end else cnt_b <= 0;
        end
    end

    // ---------------- reference model ----------------
    // Architectural word values plus, per set, a recency-ordered tag list (MRU first).
    logic [31:0] arch [1024];
    int  mtag   [16][$];
    bit  mdirty [16][$];
    int  sets_c, ways_c, wlg;
    bit  cur;

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            mtag[s].delete();
            mdirty[s].delete();
        end
    endtask

    task automatic arch_init();
        for (int i = 0; i < 1024; i++) arch[i] = initw(i);
        arch[16] = 32'hAAAA_AAAA; arch[17] = 32'hCCCC_CCCC;
        arch[18] = 32'h1122_3344; arch[19] = 32'hDDDD_DDDD;
    endtask

    task automatic model_access(input bit wr, input logic [31:0] addr, input logic [31:0] d,
                                input logic [3:0] be, output int es, output bit ewb,
                                output int ewba, output logic [31:0] erd);
        int blk, s, t, wa, pos;
        bit dd;
        blk = int'(addr >> (2 + wlg));
        s = blk % sets_c;
        t = blk / sets_c;
        wa = int'(addr >> 2) & 1023;
        pos = -1;
        for (int i = 0; i < mtag[s].size(); i++) if (mtag[s][i] == t) pos = i;
        ewb = 0; ewba = 0;
        if (pos >= 0) begin
            es = 0;
            dd = mdirty[s][pos];
            mtag[s].delete(pos);
            mdirty[s].delete(pos);
            mtag[s].push_front(t);
            mdirty[s].push_front(dd | wr);
        end else begin
            es = 5;
            if (mtag[s].size() == ways_c) begin
                ewb  = mdirty[s][mtag[s].size() - 1];
                ewba = mtag[s][mtag[s].size() - 1] * sets_c + s;
                if (ewb) es = 9;
                void'(mtag[s].pop_back());
                void'(mdirty[s].pop_back());
            end
            mtag[s].push_front(t);
            mdirty[s].push_front(wr);
        end
        erd = arch[wa];
        if (wr)
            for (int b = 0; b < 4; b++)
                if (be[b]) arch[wa][8*b +: 8] = d[8*b +: 8];
    endtask

    // ---------------- observation mux ----------------
    logic        bw, mmr, mmw, wout_nz;
    logic [31:0] baddr, rdout;
    assign bw      = cur ? ifb.BUSYWAIT      : ifa.BUSYWAIT;
    assign mmr     = cur ? ifb.MEM_MEM_READ  : ifa.MEM_MEM_READ;
    assign mmw     = cur ? ifb.MEM_MEM_WRITE : ifa.MEM_MEM_WRITE;
    assign baddr   = cur ? 32'(ifb.MEM_BLOCK_ADDR) : 32'(ifa.MEM_BLOCK_ADDR);
    assign rdout   = cur ? ifb.CACHE_READ_OUT : ifa.CACHE_READ_OUT;
    assign wout_nz = cur ? |ifb.MEM_WRITE_OUT : |ifa.MEM_WRITE_OUT;

    logic [255:0] last_wb;

    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] d,
                          input logic [3:0] be);
        int es, ewba, stall, nrd, wba, rda, s;
        bit ewb, saw_wb, saw_rd;
        logic [31:0] erd;
        logic [3:0] seen;
        model_access(wr, addr, d, be, es, ewb, ewba, erd);
        @(negedge clk);
        mem_read = !wr; mem_write = wr; mem_address = addr; data_in = d; byte_en = be;
        #1;
        stall = 0; nrd = 0; wba = 0; rda = 0; saw_wb = 0; saw_rd = 0;
        while (bw && stall < 50) begin
            if (stall == 0 && !wr) chk("rd_zero_on_miss", rdout, 0);
            if (mmw && !saw_wb) begin
                saw_wb = 1;
                wba = int'(baddr);
                last_wb = cur ? ifb.MEM_WRITE_OUT : 256'(ifa.MEM_WRITE_OUT);
            end
            if (mmr) begin
                if (!saw_rd) rda = int'(baddr);
                saw_rd = 1;
                nrd++;
            end
            stall++;
            @(negedge clk); #1;
        end
        chk("stall_cycles", stall, es);
        if (es > 0) begin
            chk("fetch_addr", rda, addr >> (2 + wlg));
            chk("fetch_cycles", nrd, 4);
        end
        chk("wback_seen", saw_wb, ewb);
        if (ewb) chk("wback_addr", wba, ewba);
        if (!wr) chk("load_data", rdout, erd);
        @(posedge clk); #1;
        mem_read = 0; mem_write = 0;
        if (cur) begin
            s = int'(addr >> 5) % 16;
            seen = 0;
            for (int w = 0; w < 4; w++) seen[dut_b.age_q[s][w]] = 1'b1;
            chk("age_perm", seen, 4'hF);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++)
            access($urandom_range(0, 1) == 1, $urandom_range(0, 1023) * 4, $urandom, 4'($urandom));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1; mem_read = 0; mem_write = 0; mem_address = 0; data_in = 0; byte_en = 0;
        cur = 0; sets_c = 8; ways_c = 2; wlg = 2;
        mem_init = 1;
        arch_init();
        @(posedge clk); #1 mem_init = 0;
        do_reset();

        @(negedge clk);
        chk("rst_busywait", bw, 0);
        chk("rst_mem_read", mmr, 0);
        chk("rst_mem_write", mmw, 0);
        chk("rst_block_addr", baddr, 0);
        chk("rst_write_out", wout_nz, 0);
        chk("rst_read_out", rdout, 0);

        access(0, 32'h48, 0, 0);                  // cold miss
        access(1, 32'h48, 32'h0000_AB00, 4'b0010); // byte store hit
        access(0, 32'h48, 0, 0);
        chk("byte_merge", rdout, 32'h1122_AB44);
        access(0, 32'hC8, 0, 0);
        access(0, 32'h148, 0, 0);                 // dirty LRU eviction
        chk("wb_word2", last_wb[95:64], 32'h1122_AB44);
        access(0, 32'h40, 0, 0);
        access(0, 32'hC0, 0, 0);
        access(0, 32'h40, 0, 0);
        access(0, 32'h140, 0, 0);
        access(0, 32'h40, 0, 0);

        // abandon a fetch with reset in its second cycle
        @(negedge clk);
        mem_read = 1; mem_address = 32'hC8;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst_abort_mem_read", mmr, 0);
        chk("rst_abort_busywait", bw, 1);
        mem_read = 0;
        model_reset();
        access(0, 32'h48, 0, 0);

        rand_phase(300);

        // wider geometry: 5 tags into set 3, then random traffic
        cur = 1; sets_c = 16; ways_c = 4; wlg = 3;
        @(negedge clk);
        mem_init = 1;
        arch_init();
        @(posedge clk); #1 mem_init = 0;
        do_reset();
        for (int t = 0; t < 5; t++) access(0, 32'(t * 512 + 96), 0, 0);
        access(0, 32'h60, 0, 0);
        rand_phase(250);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
